// File: rtl/frame_tx_packer.sv
// Transmit frame builder: HDR0,HDR1,CHAN,DATA x len,CRC,TRL0,TRL1 as 16-bit big-endian words.
// Latency: request accepted at edge T puts HDR0 on data_out after edge T+1; one word per cycle.
// Backpressure: req_ready is high only in IDLE; no output stall, the downstream must take every word.
//
// Ports:
//   clk_in, rst                    clock, asynchronous active-high reset
//   req_valid/req_ready            request handshake (fields held stable until accepted)
//   req_channel, req_len,          one-hot channel, payload length (1..8 words),
//   req_payload, req_crc_inv       right-aligned payload, CRC inversion for error injection
//   data_out, data_out_vld         registered frame word stream and its qualifier
//   frame_done                     pulse alongside the TRL1 word
//   req_err                        pulse one cycle after an illegal request is consumed
module frame_tx_packer #(
  parameter logic [31:0] HEADER     = 32'hE0E0E0E0,
  parameter logic [31:0] TRAILER    = 32'h0E0E0E0E,
  parameter logic [15:0] IDLE_WORD  = 16'h0000,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [7:0]   req_channel,
  input  logic [3:0]   req_len,
  input  logic [127:0] req_payload,
  input  logic         req_crc_inv,
  output logic [15:0]  data_out,
  output logic         data_out_vld,
  output logic         frame_done,
  output logic         req_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR0, S_HDR1, S_CHAN, S_DATA, S_CRC, S_TRL0, S_TRL1, S_GAP
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [7:0]     r_chan;
  logic [3:0]     r_len;
  logic [2:0]     r_cnt;
  logic [127:0]   r_shift;
  logic           r_inv;
  logic [15:0]    r_crc;
  logic [3:0]     r_gap;

  logic           w_accept;
  logic           w_legal;
  logic           w_last_data;
  logic           w_gap_done;
  logic [7:0]     w_shamt;
  logic [15:0]    w_data_word;
  logic [15:0]    w_dout_nxt;
  logic           w_vld_nxt;
  logic           w_done_nxt;
  logic           w_err_nxt;

  // CRC-16/CCITT (poly 0x1021, MSB first) advanced by one whole 16-bit word.
  function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [15:0] word);
    logic [15:0] v;
    v = crc ^ word;
    for (int i = 0; i < 16; i++) begin
      v = v[15] ? ({v[14:0], 1'b0} ^ 16'h1021) : {v[14:0], 1'b0};
    end
    return v;
  endfunction

  assign req_ready   = (r_state == S_IDLE);
  assign w_accept    = req_valid && req_ready;
  assign w_legal     = (req_channel != 8'h00) &&
                       ((req_channel & (req_channel - 8'd1)) == 8'h00) &&
                       (req_len != 4'd0) && (req_len <= 4'd8);
  // Left-align the used payload words so DATA always emits the top 16 bits.
  assign w_shamt     = {4'd8 - req_len, 4'b0000};
  assign w_data_word = r_shift[127:112];
  assign w_last_data = ({1'b0, r_cnt} == (r_len - 4'd1));
  assign w_gap_done  = (r_gap == 4'(GAP_CYCLES - 1));

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the word to register; outputs therefore lag the state by one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_dout_nxt  = IDLE_WORD;
    w_vld_nxt   = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_legal) w_state_nxt = S_HDR0;
          else         w_err_nxt   = 1'b1;
        end
      end
      S_HDR0: begin
        w_dout_nxt  = HEADER[31:16];
        w_vld_nxt   = 1'b1;
        w_state_nxt = S_HDR1;
      end
      S_HDR1: begin
        w_dout_nxt  = HEADER[15:0];
        w_vld_nxt   = 1'b1;
        w_state_nxt = S_CHAN;
      end
      S_CHAN: begin
        w_dout_nxt  = {8'h00, r_chan};
        w_vld_nxt   = 1'b1;
        w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_dout_nxt = w_data_word;
        w_vld_nxt  = 1'b1;
        if (w_last_data) w_state_nxt = S_CRC;
      end
      S_CRC: begin
        w_dout_nxt  = r_inv ? ~r_crc : r_crc;
        w_vld_nxt   = 1'b1;
        w_state_nxt = S_TRL0;
      end
      S_TRL0: begin
        w_dout_nxt  = TRAILER[31:16];
        w_vld_nxt   = 1'b1;
        w_state_nxt = S_TRL1;
      end
      S_TRL1: begin
        w_dout_nxt  = TRAILER[15:0];
        w_vld_nxt   = 1'b1;
        w_done_nxt  = 1'b1;
        w_state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (w_gap_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      data_out     <= IDLE_WORD;
      data_out_vld <= 1'b0;
      frame_done   <= 1'b0;
      req_err      <= 1'b0;
      r_chan       <= 8'h00;
      r_len        <= 4'd0;
      r_cnt        <= 3'd0;
      r_shift      <= '0;
      r_inv        <= 1'b0;
      r_crc        <= 16'h0000;
      r_gap        <= 4'd0;
    end else begin
      data_out     <= w_dout_nxt;
      data_out_vld <= w_vld_nxt;
      frame_done   <= w_done_nxt;
      req_err      <= w_err_nxt;
      if (w_accept) begin
        r_chan  <= req_channel;
        r_len   <= req_len;
        r_inv   <= req_crc_inv;
        r_crc   <= 16'h0000;
        r_cnt   <= 3'd0;
        r_shift <= req_payload << w_shamt;
      end
      // CRC absorbs the word being emitted, so it is final when CRC state is reached.
      if (r_state == S_DATA) begin
        r_crc   <= crc16_upd(r_crc, w_data_word);
        r_shift <= {r_shift[111:0], 16'h0000};
        r_cnt   <= w_last_data ? 3'd0 : r_cnt + 3'd1;
      end
      if (r_state == S_TRL1) r_gap <= 4'd0;
      if (r_state == S_GAP)  r_gap <= r_gap + 4'd1;
    end
  end

endmodule

// File: tb/tb_frame_tx_packer.sv
module tb_frame_tx_packer;
  localparam int GAP = 1;

  logic         clk_in = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [7:0]   req_channel = 8'h00;
  logic [3:0]   req_len = 4'd0;
  logic [127:0] req_payload = '0;
  logic         req_crc_inv = 1'b0;
  logic [15:0]  data_out;
  logic         data_out_vld;
  logic         frame_done;
  logic         req_err;

  frame_tx_packer #(.GAP_CYCLES(GAP)) dut (
    .clk_in(clk_in), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_channel(req_channel), .req_len(req_len),
    .req_payload(req_payload), .req_crc_inv(req_crc_inv),
    .data_out(data_out), .data_out_vld(data_out_vld),
    .frame_done(frame_done), .req_err(req_err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic        vld;
    logic [15:0] dat;
    logic        done;
    logic        err;
  } out_t;

  typedef struct {
    logic [7:0]   ch;
    logic [3:0]   len;
    logic [127:0] pl;
    logic         inv;
    int           wait_cyc;
    int           rst_after;
  } req_t;

  out_t        exp_q[$];
  out_t        exp_cur = '0;
  logic        exp_rdy = 1'b1;
  logic [15:0] frm[$];
  req_t        rq[$];
  req_t        cur_req;
  req_t        nxt;
  bit          have_nxt = 0;
  bit          acc = 0;
  int          dly = 0;
  int          rst_cd = 0;
  int          rst_hold = 0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic bit legal(input req_t r);
    return (r.ch != 8'h00) && ((r.ch & (r.ch - 8'd1)) == 8'h00) && (r.len >= 4'd1) && (r.len <= 4'd8);
  endfunction

  // Whole frame as a word list; CRC computed one bit at a time over the data words.
  function automatic void build_frame(input req_t r);
    logic [15:0] crc;
    logic [15:0] d;
    logic        fb;
    crc = 16'h0000;
    frm.delete();
    frm.push_back(16'hE0E0);
    frm.push_back(16'hE0E0);
    frm.push_back({8'h00, r.ch});
    for (int k = 0; k < int'(r.len); k++) begin
      d = r.pl[16*(int'(r.len)-k)-1 -: 16];
      frm.push_back(d);
      for (int b = 15; b >= 0; b--) begin
        fb  = crc[15] ^ d[b];
        crc = {crc[14:0], 1'b0};
        if (fb) crc = crc ^ 16'h1021;
      end
    end
    frm.push_back(r.inv ? ~crc : crc);
    frm.push_back(16'h0E0E);
    frm.push_back(16'h0E0E);
  endfunction

  // Called at each rising edge with the inputs the DUT sampled on that edge.
  task automatic model_step();
    out_t o;
    bit   ok;
    acc = 0;
    if (rst) begin
      exp_q.delete();
      exp_cur = '0;
      exp_rdy = 1'b1;
      return;
    end
    acc = req_valid && (exp_q.size() == 0);
    ok  = acc && legal(cur_req);
    o   = '0;
    if (exp_q.size() > 0) o = exp_q.pop_front();
    if (acc && !ok) o.err = 1'b1;
    if (ok) begin
      build_frame(cur_req);
      foreach (frm[i]) begin
        out_t e;
        e      = '0;
        e.vld  = 1'b1;
        e.dat  = frm[i];
        e.done = (i == frm.size() - 1);
        exp_q.push_back(e);
      end
      for (int g = 0; g < GAP; g++) exp_q.push_back('0);
      if (cur_req.rst_after > 0) rst_cd = cur_req.rst_after;
    end
    exp_cur = o;
    exp_rdy = (exp_q.size() == 0);
  endtask

  task automatic drive_step();
    if (acc) begin
      req_valid   = 1'b0;
      req_payload = {$urandom, $urandom, $urandom, $urandom};
      req_channel = 8'($urandom);
      req_len     = 4'($urandom);
    end
    if (!req_valid && !rst) begin
      if (!have_nxt && rq.size() > 0) begin
        nxt      = rq.pop_front();
        have_nxt = 1;
        dly      = nxt.wait_cyc;
      end
      if (have_nxt) begin
        if (dly > 0) dly--;
        else begin
          cur_req     = nxt;
          have_nxt    = 0;
          req_valid   = 1'b1;
          req_channel = nxt.ch;
          req_len     = nxt.len;
          req_payload = nxt.pl;
          req_crc_inv = nxt.inv;
        end
      end
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_async_vld", {31'b0, data_out_vld}, 32'd0);
    check("rst_async_dat", {16'b0, data_out}, 32'h0000);
    check("rst_async_done", {31'b0, frame_done}, 32'd0);
    check("rst_async_rdy", {31'b0, req_ready}, 32'd1);
    exp_q.delete();
    exp_cur  = '0;
    exp_rdy  = 1'b1;
    rst_hold = 2;
  endtask

  function automatic req_t mk(input logic [7:0] ch, input logic [3:0] len, input logic [127:0] pl,
                              input logic inv, input int w, input int ra);
    req_t r;
    r.ch = ch; r.len = len; r.pl = pl; r.inv = inv; r.wait_cyc = w; r.rst_after = ra;
    return r;
  endfunction

  always @(negedge clk_in) begin
    check("data_out_vld", {31'b0, data_out_vld}, {31'b0, exp_cur.vld});
    check("data_out", {16'b0, data_out}, {16'b0, exp_cur.dat});
    check("frame_done", {31'b0, frame_done}, {31'b0, exp_cur.done});
    check("req_err", {31'b0, req_err}, {31'b0, exp_cur.err});
    check("req_ready", {31'b0, req_ready}, {31'b0, exp_rdy});
  end

  initial begin
    req_t r;
    logic [127:0] p2;
    logic [15:0]  c1 [7];
    p2 = 128'h0123456789ABCDEFFEDCBA9876543210;
    c1 = '{16'hE0E0, 16'hE0E0, 16'h0001, 16'hA55A, 16'h1934, 16'h0E0E, 16'h0E0E};

    // Hand-computed expectations pinning the frame model.
    build_frame(mk(8'h01, 4'd1, 128'hA55A, 1'b0, 0, 0));
    check("pin_c1_len", frm.size(), 7);
    for (int i = 0; i < 7; i++) check("pin_c1_word", {16'b0, frm[i]}, {16'b0, c1[i]});
    build_frame(mk(8'h01, 4'd1, 128'hA55A, 1'b1, 0, 0));
    check("pin_c4_crc", {16'b0, frm[4]}, 32'hE6CB);
    build_frame(mk(8'h02, 4'd8, p2, 1'b0, 0, 0));
    check("pin_c2_len", frm.size(), 14);
    check("pin_c2_first", {16'b0, frm[3]}, 32'h0123);
    check("pin_c2_last", {16'b0, frm[10]}, 32'h3210);
    frm.delete();

    rq.push_back(mk(8'h01, 4'd1, 128'hA55A, 1'b0, 2, 0));
    rq.push_back(mk(8'h02, 4'd8, p2, 1'b0, 3, 0));
    rq.push_back(mk(8'h80, 4'd3, 128'h1111_2222_3333, 1'b0, 0, 0));   // held during previous frame
    rq.push_back(mk(8'h01, 4'd1, 128'hA55A, 1'b1, 2, 0));
    rq.push_back(mk(8'h03, 4'd1, 128'h1234, 1'b0, 2, 0));
    rq.push_back(mk(8'h01, 4'd0, 128'h1234, 1'b0, 1, 0));
    rq.push_back(mk(8'h01, 4'd9, 128'h1234, 1'b0, 0, 0));
    rq.push_back(mk(8'h00, 4'd2, 128'h1234, 1'b0, 0, 0));
    rq.push_back(mk(8'h04, 4'd8, p2, 1'b0, 2, 6));                    // reset lands mid-DATA
    rq.push_back(mk(8'h04, 4'd8, p2, 1'b0, 10, 0));
    for (int i = 0; i < 50; i++) begin
      r = mk(8'h01 << $urandom_range(0, 7), 4'($urandom_range(1, 8)),
             {$urandom, $urandom, $urandom, $urandom}, ($urandom_range(0, 3) == 0),
             $urandom_range(0, 3), 0);
      case ($urandom_range(0, 9))
        0: r.ch  = r.ch | (8'h01 << $urandom_range(0, 7)) | 8'h81;
        1: r.len = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
        default: ;
      endcase
      rq.push_back(r);
    end

    while (cyc < 5000 && !(cyc > 4 && rq.size() == 0 && !have_nxt && !req_valid &&
                           exp_q.size() == 0 && rst_cd == 0 && rst_hold == 0)) begin
      @(posedge clk_in);
      cyc++;
      model_step();
      #1;
      if (cyc == 3) rst = 1'b0;
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst = 1'b0;
      end
      if (rst_cd > 0) begin
        rst_cd--;
        if (rst_cd == 0) do_reset();
      end
      drive_step();
    end
    check("run_within_budget", {31'b0, cyc < 5000}, 32'd1);
    repeat (3) @(posedge clk_in);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
